// File: rtl/dmux4_sched_pkg.sv
// dmux4_sched shared types: FSM states, channel count and the
// round-robin picker used by the arbitration state.
package dmux4_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  function automatic pick_t rr_pick(
    input logic [NUM_CH-1:0] mask,
    input logic [1:0]        ptr
  );
    pick_t      r;
    logic [1:0] c;
    r = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = ptr + 2'(k);
      if (!r.found && mask[c]) begin
        r.found = 1'b1;
        r.idx   = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dmux4_sched_if.sv
// dmux4_sched bus: upstream valid/ready item port, one-hot
// downstream channel port and the per-channel credit returns.
interface dmux4_sched_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_dest;
  logic [3:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_ready;
  logic [3:0]        credit_ret;

  modport master (
    output in_valid, in_data, in_dest,
    output out_ready, credit_ret,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dest,
    input  out_ready, credit_ret,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dmux4_credit_ctr.sv
// One output channel's credit counter: decrements on a send,
// increments on a return, saturates at CREDIT_MAX with sticky error.
module dmux4_credit_ctr #(
  parameter int CREDIT_MAX = 4,
  parameter int CW = $clog2(CREDIT_MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec_i,
  input  logic ret_i,
  output logic nz_o,
  output logic err_o
);

  localparam logic [CW-1:0] MAXV = CW'(CREDIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // next credit value; simultaneous send and return cancel out
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (dec_i && !ret_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
    end else if (ret_i && !dec_i) begin
      if (cnt_q == MAXV) err_d = 1'b1;
      else               cnt_d = cnt_q + CW'(1);
    end
  end

  // counter and sticky error registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= MAXV;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign nz_o  = (cnt_q != '0);
  assign err_o = err_q;

endmodule

// File: rtl/dmux4_sched.sv
// dmux4_sched: credit-gated 1-to-4 item scheduler (round-robin or tagged).
// Optional per-channel handshake counters: define DMUX4_SCHED_STATS_EN.
module dmux4_sched
  import dmux4_sched_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CREDIT_MAX = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_directed,
  dmux4_sched_if.slave   bus,
  output logic           busy,
  output logic           err_credit
`ifdef DMUX4_SCHED_STATS_EN
  ,
  input  logic           stat_clr,
  output logic [63:0]    stat_cnt
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [1:0]        dest_q, dest_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        rr_q, rr_d;
  logic              dir_q, dir_d;
  logic [3:0]        oval_q, oval_d;
  logic [3:0]        nz, err, dec;
  pick_t             pick;
  logic              go;
  logic [1:0]        gsel;
  logic              hs;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dmux4_credit_ctr #(
      .CREDIT_MAX(CREDIT_MAX)
    ) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .dec_i (dec[i]),
      .ret_i (bus.credit_ret[i]),
      .nz_o  (nz[i]),
      .err_o (err[i])
    );
  end

  // capture, arbitrate, then hold the item until its channel takes it
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    dir_d   = dir_q;
    oval_d  = oval_q;
    odata_d = odata_q;
    pick    = rr_pick(nz, rr_q);
    go      = 1'b0;
    gsel    = pick.idx;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          dest_d  = bus.in_dest;
          state_d = ARB;
        end
      end
      ARB: begin
        if (cfg_directed) begin
          go   = nz[dest_q];
          gsel = dest_q;
        end else begin
          go   = pick.found;
        end
        if (go) begin
          sel_d   = gsel;
          dir_d   = cfg_directed;
          oval_d  = 4'b0001 << gsel;
          odata_d = data_q;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready[sel_q]) begin
          hs      = 1'b1;
          oval_d  = '0;
          state_d = IDLE;
          if (!dir_q) rr_d = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dest_q  <= '0;
      sel_q   <= '0;
      rr_q    <= 2'd3;
      dir_q   <= 1'b0;
      oval_q  <= '0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
      oval_q  <= oval_d;
      odata_q <= odata_d;
    end
  end

  assign dec           = hs ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = oval_q;
  assign bus.out_data  = odata_q;
  assign busy          = (state_q != IDLE);
  assign err_credit    = |err;

`ifdef DMUX4_SCHED_STATS_EN
  logic [15:0] st_q [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_st
    // per-channel completed handshake count, clear wins
    always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) st_q[i] <= '0;
      else if (dec[i])        st_q[i] <= st_q[i] + 16'd1;
    end
    assign stat_cnt[16*i +: 16] = st_q[i];
  end
`endif

endmodule

// File: tb/tb_dmux4_sched.sv
// Randomized self-checking bench for dmux4_sched against a
// credit/round-robin reference model kept in plain arrays.
module tb_dmux4_sched;
  import dmux4_sched_pkg::*;

  localparam int CMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_directed = 1'b0;
  logic busy, err_credit;
`ifdef DMUX4_SCHED_STATS_EN
  logic        stat_clr = 1'b0;
  logic [63:0] stat_cnt;
`endif

  always #5 clk = ~clk;

  dmux4_sched_if #(.DATA_W(8)) bus ();

  dmux4_sched #(
    .DATA_W(8),
    .CREDIT_MAX(CMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_directed (cfg_directed),
    .bus          (bus),
    .busy         (busy),
    .err_credit   (err_credit)
`ifdef DMUX4_SCHED_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int m_cr [4];
  int m_rr;
  bit m_err;

  function automatic int m_pick(input bit dir, input int dst);
    if (dir) return (m_cr[dst] > 0) ? dst : -1;
    for (int k = 1; k <= 4; k++) begin
      if (m_cr[(m_rr + k) % 4] > 0) return (m_rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_grant(input int ch, input bit dir);
    m_cr[ch] = m_cr[ch] - 1;
    if (!dir) m_rr = ch;
  endtask

  task automatic m_ret(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (m_cr[i] == CMAX) m_err = 1'b1;
        else m_cr[i] = m_cr[i] + 1;
      end
    end
  endtask

  function automatic int crd(input int i);
    case (i)
      0: return int'(dut.g_ch[0].u_ctr.cnt_q);
      1: return int'(dut.g_ch[1].u_ctr.cnt_q);
      2: return int'(dut.g_ch[2].u_ctr.cnt_q);
      default: return int'(dut.g_ch[3].u_ctr.cnt_q);
    endcase
  endfunction

  task automatic pulse_ret(input logic [3:0] m);
    bus.credit_ret = m;
    @(negedge clk);
    bus.credit_ret = '0;
    m_ret(m);
  endtask

  task automatic refill();
    logic [3:0] m;
    for (int r = 0; r < CMAX; r++) begin
      m = '0;
      for (int i = 0; i < 4; i++) if (m_cr[i] < CMAX) m[i] = 1'b1;
      if (m != 0) pulse_ret(m);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_directed = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_dest = '0;
    bus.out_ready = '0;
    bus.credit_ret = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_cr[i] = CMAX;
    m_rr = 3;
    m_err = 1'b0;
  endtask

  // drive one item, wait for its grant, hold out_ready low for
  // 'hold' cycles (non-selected channels ready, mode flipped),
  // then complete the handshake; starts and ends on a negedge
  task automatic xfer(
    input  logic [7:0] d,
    input  logic [1:0] dst,
    input  bit         dir,
    input  int         hold,
    input  bit         ret_hs,
    output int         ch,
    output logic [7:0] od,
    output int         lat,
    output bit         stable,
    output bit         tmo
  );
    int n;
    int acc;
    logic [3:0] ov;
    ch = -1; od = '0; lat = -1; stable = 1'b1; tmo = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cfg_directed = dir;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_dest = dst;
    bus.out_ready = '0;
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = 8'($urandom);
    bus.in_dest = 2'($urandom);
    n = 0;
    while (bus.out_valid == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_valid == 0) begin
      tmo = 1'b1;
      return;
    end
    lat = cyc - acc;
    ov = bus.out_valid;
    od = bus.out_data;
    if ($countones(ov) == 1) begin
      for (int i = 0; i < 4; i++) if (ov[i]) ch = i;
    end else begin
      ch = -2;
    end
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = ~ov;
      cfg_directed = ~dir;
      @(negedge clk);
      if (bus.out_valid !== ov || bus.out_data !== od ||
          bus.in_ready !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    bus.out_ready = 4'hF;
    if (ret_hs) bus.credit_ret = ov;
    @(negedge clk);
    bus.out_ready = '0;
    bus.credit_ret = '0;
    cfg_directed = dir;
    if (bus.out_valid !== 4'b0 || bus.in_ready !== 1'b1) stable = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 4'b0 ||
        bus.out_data !== 8'h00 || busy !== 1'b0 || err_credit !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b ov=%b od=%h busy=%b err=%b want 1 0000 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, busy, err_credit);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (crd(i) != m_cr[i]) begin
        n_bad++;
        $display("FAIL reset_credit%0d: got %0d want %0d", i, crd(i), m_cr[i]);
      end
    end
  endtask

  task automatic test_first_item();
    int ch, lat, exp;
    logic [7:0] od;
    bit st, tmo;
    exp = m_pick(1'b0, 0);
    xfer(8'hA5, 2'd0, 1'b0, 0, 1'b0, ch, od, lat, st, tmo);
    n_cmp++;
    if (tmo || ch != exp || od !== 8'hA5) begin
      n_bad++;
      $display("FAIL first_item: tmo=%0d ch=%0d data=%h want ch=%0d data=a5",
               tmo, ch, od, exp);
    end
    n_cmp++;
    if (lat != 2) begin
      n_bad++;
      $display("FAIL first_latency: got %0d want 2", lat);
    end
    if (exp >= 0) m_grant(exp, 1'b0);
    n_cmp++;
    if (crd(0) != m_cr[0] || !st) begin
      n_bad++;
      $display("FAIL first_credit: credit0=%0d want %0d stable=%0d", crd(0), m_cr[0], st);
    end
  endtask

  task automatic test_back_to_back();
    int ch, lat, exp, t0, tprev;
    logic [7:0] d, od;
    bit st, tmo;
    tprev = -1;
    for (int i = 0; i < 7; i++) begin
      d = 8'($urandom);
      exp = m_pick(1'b0, 0);
      t0 = cyc;
      xfer(d, 2'($urandom), 1'b0, 0, 1'b0, ch, od, lat, st, tmo);
      n_cmp++;
      if (tmo || ch != exp || od !== d || !st) begin
        n_bad++;
        $display("FAIL b2b_grant%0d: ch=%0d data=%h tmo=%0d st=%0d want ch=%0d data=%h",
                 i, ch, od, tmo, st, exp, d);
      end
      if (tprev >= 0) begin
        n_cmp++;
        if (t0 - tprev != 3) begin
          n_bad++;
          $display("FAIL b2b_period%0d: got %0d cycles want 3", i, t0 - tprev);
        end
      end
      tprev = t0;
      if (exp >= 0) m_grant(exp, 1'b0);
    end
    refill();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (crd(i) != m_cr[i]) begin
        n_bad++;
        $display("FAIL b2b_refill%0d: got %0d want %0d", i, crd(i), m_cr[i]);
      end
    end
  endtask

  task automatic test_directed_stall();
    int ch, lat, exp, n;
    logic [7:0] d, od;
    bit st, tmo, ok;
    for (int i = 0; i < CMAX; i++) begin
      d = 8'($urandom);
      exp = m_pick(1'b1, 2);
      xfer(d, 2'd2, 1'b1, 0, 1'b0, ch, od, lat, st, tmo);
      n_cmp++;
      if (tmo || ch != exp || od !== d) begin
        n_bad++;
        $display("FAIL dir_grant%0d: ch=%0d data=%h want ch=%0d data=%h", i, ch, od, exp, d);
      end
      if (exp >= 0) m_grant(exp, 1'b1);
    end
    d = 8'($urandom);
    cfg_directed = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_dest = 2'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b1 || bus.out_valid !== 4'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL dir_stall: busy=%b ov=%b want busy=1 ov=0000", busy, bus.out_valid);
    end
    pulse_ret(4'b0100);
    n_cmp++;
    if (bus.out_valid !== 4'b0) begin
      n_bad++;
      $display("FAIL dir_release_early: ov=%b want 0000", bus.out_valid);
    end
    @(negedge clk);
    exp = m_pick(1'b1, 2);
    n_cmp++;
    if (exp < 0 || bus.out_valid !== (4'b0001 << exp) || bus.out_data !== d) begin
      n_bad++;
      $display("FAIL dir_release: ov=%b data=%h want ch%0d data=%h",
               bus.out_valid, bus.out_data, exp, d);
    end
    n = 0;
    while (bus.out_valid == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.out_ready = 4'hF;
    @(negedge clk);
    bus.out_ready = '0;
    if (exp >= 0) m_grant(exp, 1'b1);
    n_cmp++;
    if (crd(2) != m_cr[2]) begin
      n_bad++;
      $display("FAIL dir_credit2: got %0d want %0d", crd(2), m_cr[2]);
    end
    refill();
  endtask

  task automatic test_skip();
    int ch, lat, exp;
    logic [7:0] d, od;
    bit st, tmo;
    while (m_cr[1] > 0) begin
      xfer(8'($urandom), 2'd1, 1'b1, 0, 1'b0, ch, od, lat, st, tmo);
      if (tmo) break;
      m_grant(1, 1'b1);
    end
    n_cmp++;
    if (crd(1) != 0) begin
      n_bad++;
      $display("FAIL skip_drain: credit1=%0d want 0", crd(1));
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      exp = m_pick(1'b0, 0);
      xfer(d, 2'($urandom), 1'b0, 0, 1'b0, ch, od, lat, st, tmo);
      n_cmp++;
      if (tmo || ch != exp || od !== d) begin
        n_bad++;
        $display("FAIL skip_grant%0d: ch=%0d data=%h want ch=%0d data=%h", i, ch, od, exp, d);
      end
      if (exp >= 0) m_grant(exp, 1'b0);
    end
    refill();
  endtask

  task automatic test_stall_hold();
    int ch, lat, exp;
    logic [7:0] d, od;
    bit st, tmo;
    exp = m_pick(1'b1, 0);
    xfer(8'h3C, 2'd0, 1'b1, 0, 1'b0, ch, od, lat, st, tmo);
    if (exp >= 0) m_grant(exp, 1'b1);
    d = 8'($urandom);
    exp = m_pick(1'b1, 0);
    xfer(d, 2'd0, 1'b1, 5, 1'b1, ch, od, lat, st, tmo);
    n_cmp++;
    if (tmo || !st || ch != exp || od !== d) begin
      n_bad++;
      $display("FAIL hold_stable: tmo=%0d st=%0d ch=%0d data=%h want ch=%0d data=%h",
               tmo, st, ch, od, exp, d);
    end
    n_cmp++;
    if (crd(0) != m_cr[0] || err_credit !== m_err) begin
      n_bad++;
      $display("FAIL hold_dec_ret: credit0=%0d err=%b want %0d %b",
               crd(0), err_credit, m_cr[0], m_err);
    end
    pulse_ret(4'b0001);
    n_cmp++;
    if (err_credit !== m_err) begin
      n_bad++;
      $display("FAIL err_early: err=%b want %b", err_credit, m_err);
    end
    pulse_ret(4'b0001);
    n_cmp++;
    if (err_credit !== m_err || crd(0) != m_cr[0]) begin
      n_bad++;
      $display("FAIL err_sat: err=%b credit0=%0d want %b %0d",
               err_credit, crd(0), m_err, m_cr[0]);
    end
  endtask

  task automatic test_random();
    int ch, lat, exp, hold;
    logic [7:0] d, od;
    logic [1:0] dst;
    bit dir, st, tmo;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) pulse_ret(4'($urandom));
      d = 8'($urandom);
      dst = 2'($urandom);
      dir = 1'($urandom);
      hold = $urandom_range(0, 2);
      if (m_pick(dir, int'(dst)) < 0) refill();
      exp = m_pick(dir, int'(dst));
      xfer(d, dst, dir, hold, 1'b0, ch, od, lat, st, tmo);
      n_cmp++;
      if (tmo || ch != exp || od !== d || !st || lat != 2) begin
        n_bad++;
        $display("FAIL rand%0d: ch=%0d data=%h lat=%0d st=%0d tmo=%0d want ch=%0d data=%h lat=2",
                 i, ch, od, lat, st, tmo, exp, d);
      end
      if (exp >= 0) m_grant(exp, dir);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (crd(i) != m_cr[i]) begin
        n_bad++;
        $display("FAIL rand_credit%0d: got %0d want %0d", i, crd(i), m_cr[i]);
      end
    end
    n_cmp++;
    if (err_credit !== m_err) begin
      n_bad++;
      $display("FAIL rand_err: got %b want %b", err_credit, m_err);
    end
  endtask

  task automatic test_reset_send();
    int ch, lat, exp, n;
    logic [7:0] od;
    bit st, tmo, ok;
    cfg_directed = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    bus.in_dest = 2'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.out_valid == 0) begin
      n_bad++;
      $display("FAIL rst_send_setup: ov=%b want nonzero", bus.out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_cr[i] = CMAX;
    m_rr = 3;
    m_err = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 4'b0 || bus.in_ready !== 1'b1 ||
        busy !== 1'b0 || err_credit !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_send_out: ov=%b rdy=%b busy=%b err=%b want 0000 1 0 0",
               bus.out_valid, bus.in_ready, busy, err_credit);
    end
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (crd(i) != m_cr[i]) ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid !== 4'b0) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rst_send_quiet: credits/out_valid not at reset values ov=%b", bus.out_valid);
    end
    exp = m_pick(1'b0, 0);
    xfer(8'hC3, 2'd2, 1'b0, 0, 1'b0, ch, od, lat, st, tmo);
    n_cmp++;
    if (tmo || ch != exp || od !== 8'hC3) begin
      n_bad++;
      $display("FAIL rst_send_first: ch=%0d data=%h want ch=%0d data=c3", ch, od, exp);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_dest = '0;
    bus.out_ready = '0;
    bus.credit_ret = '0;
    @(negedge clk);
    test_reset();
    test_first_item();
    test_back_to_back();
    test_directed_stall();
    test_skip();
    test_stall_hold();
    test_random();
    test_reset_send();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmux4_sched.md
Name: dmux4_sched

Overview:
- Sequencing and scheduling controller that sits in front of a registered 1-to-4 demux.
- Accepts one data item at a time over a valid/ready handshake and picks a destination channel, either round-robin or directed by a per-item tag.
- Presents the item to the chosen channel with a one-hot valid.
- Keeps per-channel credit counters so a full consumer is never driven.

Parameters:
- DATA_W, 8: width of in_data/out_data.
- CREDIT_MAX, 4: credits per output channel after reset (1..15).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- cfg_directed  input  1  0 = round-robin routing, 1 = route to in_dest; sampled only in ARB.
- in_valid  input  1  upstream item valid.
- in_ready  output  1  block can accept an item.
- in_data  input  DATA_W  upstream item.
- in_dest  input  2  destination tag, captured with in_data.
- out_valid  output  4  one-hot: item valid for channel i.
- out_data  output  DATA_W  shared data bus to all channels.
- out_ready  input  4  channel i accepts item.
- credit_ret  input  4  per-channel 1-cycle pulse returning one credit.
- busy  output  1  high whenever state != IDLE.
- err_credit  output  1  sticky: credit returned while the counter was already at CREDIT_MAX.

Behaviour:
- Reset values (rst_n low at posedge):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, err_credit=0.
  - All credit counters = CREDIT_MAX; rr_ptr=3, so the first round-robin grant goes to ch0.
  - Reset mid-operation discards the held item; no out_valid pulse follows.
- State IDLE:
  - in_ready=1.
  - On in_valid: capture in_data and in_dest into the hold register, then go to ARB.
- State ARB:
  - in_ready=0.
  - Directed mode: candidate = held dest; eligible if its credit > 0.
  - Round-robin mode: candidate = first channel with credit > 0, searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - If a candidate is eligible: register sel, drive out_valid[sel]=1 and out_data=held data on the next cycle, go to SEND.
  - If no candidate is eligible: stay in ARB and re-evaluate every cycle (stall).
- State SEND:
  - out_valid[sel] and out_data are held stable until out_ready[sel]=1.
  - On the handshake cycle:
    - credit[sel] decrements.
    - rr_ptr updates to sel (round-robin mode only; directed mode leaves rr_ptr unchanged).
    - Next cycle: out_valid=0, state=IDLE.
  - out_ready on non-selected channels is ignored.
- Latency and throughput:
  - Item accepted at cycle N gives earliest out_valid at N+2.
  - Minimum 3 cycles per item; in_ready does not overlap SEND.
- Credit counters:
  - Width $clog2(CREDIT_MAX+1).
  - Decrement and credit_ret[i] in the same cycle leave the counter unchanged.
  - credit_ret at CREDIT_MAX saturates the counter and sets err_credit; only reset clears it.
  - A credit returned while in ARB is visible to arbitration the following cycle.
- cfg_directed changing while in SEND has no effect on the item in flight.

Optional Feature:
- Macro: DMUX4_SCHED_STATS_EN.
- When defined:
  - Adds output stat_cnt (4x16 bits, packed, ch0 in LSBs).
  - Each 16-bit counter increments on every completed handshake for its channel and wraps at 0xFFFF to 0.
  - Counters reset to 0.
  - Adds input stat_clr: synchronous clear of all counters, with priority over increment.
- When not defined: no stat ports or counter logic exist; all other behaviour is identical.

Decomposition:
- Package dmux4_sched_pkg holds:
  - State enum: IDLE=2'd0, ARB=2'd1, SEND=2'd2.
  - NUM_CH=4.
  - Function rr_pick(mask, ptr), returning the next eligible channel index plus a found flag.
- Sub-module dmux4_credit_ctr holds one channel's credit counter, saturation logic and error flag; it is instantiated four times.

Test Plan:
- Reset then one round-robin item 8'hA5 with all out_ready=1 → out_valid=4'b0001 two cycles after acceptance, out_data=8'hA5; credit[0]=3.
- Four back-to-back round-robin items, all ready → grants ch0, ch1, ch2, ch3 in order; repeating the sequence wraps to ch0.
- Directed mode with in_dest=2 for CREDIT_MAX+1 items and no credit_ret → the first 4 items go to ch2; the 5th stalls in ARB (busy=1, out_valid=0); a credit_ret[2] pulse releases it on the next cycle.
- Round-robin with credit[1]=0 → ch1 is skipped: grants go ch0, ch2.
- out_ready[sel] held low for 5 cycles → out_valid and out_data stay stable and in_ready=0 until the handshake; a concurrent decrement and credit_ret on the same channel leaves credit unchanged; credit_ret at full sets err_credit=1.
- rst_n low during SEND → next cycle out_valid=0, in_ready=1, credits=CREDIT_MAX, and the first grant after reset goes to ch0.
